// File: rtl/iterative_muldiv_unit.sv
// Multi-cycle RV32M/RV64M execute unit: shift-add multiply and restoring divide over XLEN iterations.
// Decodes funct3/funct7 itself and reports busy/ready for pipeline stalling.
module iterative_muldiv_unit #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = $clog2(XLEN + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  input  logic            flush,
  output logic            ready,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            illegal_op
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t            state;
  logic [2:0]        op;
  logic [XLEN-1:0]   operand_m;
  logic [2*XLEN-1:0] acc;
  logic              neg_main;
  logic              neg_rem;
  logic [CNT_W-1:0]  counter;

  logic              div_op, a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0]   a_abs, b_abs;
  logic              div_by_zero, div_overflow, special;
  logic [XLEN-1:0]   special_res;

  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_shift;
  logic [XLEN:0]     div_trial;
  logic [2*XLEN-1:0] acc_next;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quot, remv, final_res;

  // Operand conditioning at acceptance: magnitudes plus recorded result signs.
  always_comb begin
    div_op   = funct3[2];
    a_signed = (funct3 == 3'b001) || (funct3 == 3'b010) ||
               (funct3 == 3'b100) || (funct3 == 3'b110);
    b_signed = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
    a_neg    = a_signed && operand_a[XLEN-1];
    b_neg    = b_signed && operand_b[XLEN-1];
    a_abs    = a_neg ? -operand_a : operand_a;
    b_abs    = b_neg ? -operand_b : operand_b;

    div_by_zero  = div_op && (operand_b == '0);
    div_overflow = div_op && !funct3[0] && operand_a[XLEN-1] &&
                   (operand_a[XLEN-2:0] == '0) && (operand_b == '1);
    special      = div_by_zero || div_overflow;

    special_res = '0;
    if (div_by_zero)
      special_res = funct3[1] ? operand_a : '1;
    else if (div_overflow)
      special_res = funct3[1] ? '0 : operand_a;
  end

  // One iteration: upper half of acc is the partial product / remainder,
  // lower half is the remaining multiplier / dividend bits (then quotient bits).
  always_comb begin
    mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, operand_m} : '0);
    div_shift = acc[2*XLEN-1:XLEN-1];
    div_trial = div_shift - {1'b0, operand_m};
    if (op[2]) begin
      if (div_trial[XLEN])
        acc_next = {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0};
      else
        acc_next = {div_trial[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    end else begin
      acc_next = {mul_sum, acc[XLEN-1:1]};
    end

    prod = neg_main ? -acc_next : acc_next;
    quot = neg_main ? -acc_next[XLEN-1:0] : acc_next[XLEN-1:0];
    remv = neg_rem  ? -acc_next[2*XLEN-1:XLEN] : acc_next[2*XLEN-1:XLEN];

    case (op)
      3'b000:                 final_res = prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: final_res = prod[2*XLEN-1:XLEN];
      3'b100, 3'b101:         final_res = quot;
      default:                final_res = remv;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      ready      <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      illegal_op <= 1'b0;
      result     <= '0;
      counter    <= '0;
      op         <= '0;
      operand_m  <= '0;
      acc        <= '0;
      neg_main   <= 1'b0;
      neg_rem    <= 1'b0;
    end else begin
      done       <= 1'b0;
      illegal_op <= 1'b0;
      if (flush) begin
        state   <= S_IDLE;
        ready   <= 1'b1;
        busy    <= 1'b0;
        counter <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              if (funct7 != 7'b0000001) begin
                illegal_op <= 1'b1;
              end else begin
                op        <= funct3;
                ready     <= 1'b0;
                busy      <= 1'b1;
                operand_m <= div_op ? b_abs : a_abs;
                acc       <= {{XLEN{1'b0}}, (div_op ? a_abs : b_abs)};
                neg_main  <= a_neg ^ b_neg;
                neg_rem   <= a_neg;
                if (special) begin
                  result  <= special_res;
                  done    <= 1'b1;
                  counter <= '0;
                  state   <= S_DONE;
                end else begin
                  counter <= CNT_W'(XLEN);
                  state   <= S_CALC;
                end
              end
            end
          end
          S_CALC: begin
            acc     <= acc_next;
            counter <= counter - CNT_W'(1);
            if (counter == CNT_W'(1)) begin
              result <= final_res;
              done   <= 1'b1;
              state  <= S_DONE;
            end
          end
          S_DONE: begin
            ready <= 1'b1;
            busy  <= 1'b0;
            state <= S_IDLE;
          end
          default: begin
            ready <= 1'b1;
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule
